fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_addr  output  32  fetch address, word-aligned.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_rsp_valid  input  1  response data valid.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-011 id_ready  input  1  decode stage consumes id_* this cycle.
REQ-012 id_valid  output  1  id_* holds a valid instruction.
REQ-013 id_pc  output  32  address of the instruction in id_instr.
REQ-014 id_instr  output  32  registered instruction word.
REQ-015 id_opcode / id_funct3 / id_funct7  output  7/3/7  combinational slices id_instr[6:0], [14:12], [31:25].

Function
REQ-016 The block SHALL implement three states: FETCH, WAIT, DRAIN; at most one request outstanding.
REQ-017 The block SHALL drive imem_req_valid = (state==FETCH) && skid empty && !redirect_valid; imem_req_addr = pc.
REQ-018 A request is accepted when imem_req_valid && imem_req_ready; the block SHALL then latch req_pc <= pc, pc <= pc+4 (mod 2^32), go to WAIT.
REQ-019 In WAIT, on imem_rsp_valid, the block SHALL capture {req_pc, imem_rsp_data} and return to FETCH; rsp_valid in FETCH is ignored.
REQ-020 Capture target: output register if !id_valid or id_ready this cycle, else one-entry skid buffer.
REQ-021 When id_valid && id_ready and skid full, the skid entry SHALL move to the output register; id_valid stays 1.
REQ-022 When id_valid && id_ready with skid empty and no capture, id_valid SHALL go 0 next cycle.
REQ-023 id_* SHALL hold stable while id_valid && !id_ready.
REQ-024 Latency: response in cycle N (output free) -> id_valid=1 in cycle N+1.
REQ-025 Throughput: with single-cycle memory and id_ready=1, one instruction per two cycles.
REQ-026 redirect_valid has highest priority: pc <= {redirect_pc[31:2],2'b00}; id_valid and skid valid SHALL clear next cycle.
REQ-027 Redirect in WAIT without same-cycle rsp -> DRAIN; with same-cycle rsp -> rsp discarded, go FETCH.
REQ-028 In DRAIN the next rsp SHALL be discarded and state -> FETCH; redirect in DRAIN updates pc, state unchanged unless rsp same cycle.
REQ-029 Redirect in FETCH: no request issued that cycle (REQ-017); next cycle fetches redirect target.
REQ-030 pc[1:0] SHALL always be 0.

Reset
REQ-031 On rst=1 at a clock edge: state=FETCH, pc=RESET_PC, req_pc=0, id_valid=0, id_pc=0, id_instr=0, skid empty; rst overrides redirect and responses.
REQ-032 Reset asserted while in WAIT/DRAIN SHALL abandon the outstanding request; the late response arriving after reset (state FETCH) is ignored.
REQ-033 First cycle after reset release: imem_req_valid=1, imem_req_addr=RESET_PC.

Verification
REQ-034 Reset release, ready=1, 1-cycle rsp returning 32'h00500093 -> id_valid=1, id_pc=0, id_opcode=7'h13, id_funct3=0; next request addr 0x4.
REQ-035 id_ready=0 held 10 cycles, memory always ready -> exactly two instructions buffered (pc 0x0 in output, 0x4 in skid), no third request; on id_ready=1, 0x4 appears next cycle.
REQ-036 Redirect to 0x100 while WAIT, rsp 3 cycles later with 0xDEADBEEF -> response discarded, id_valid never shows it, next request addr 0x100.
REQ-037 Redirect to 0x203 same cycle as rsp_valid -> rsp discarded, id_valid=0, next request addr 0x200.
REQ-038 pc=0xFFFF_FFFC accepted -> next request addr 0x0000_0000.
REQ-039 rst pulse in WAIT, stale rsp next cycle -> id_valid stays 0, request at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with one-entry skid buffer and redirect flush
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7
);
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic        id_valid_q, id_valid_d, skid_valid_q, skid_valid_d;
  logic [31:0] id_pc_q, id_pc_d, id_instr_q, id_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d, skid_instr_q, skid_instr_d;
  logic        accept, capture, out_free, rsp_done;
  assign imem_req_valid = state_q == S_FETCH && !skid_valid_q && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_done = state_q != S_FETCH && imem_rsp_valid;
  assign capture  = state_q == S_WAIT && imem_rsp_valid && !redirect_valid;
  assign out_free = !id_valid_q || id_ready;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign id_opcode = id_instr_q[6:0];
  assign id_funct3 = id_instr_q[14:12];
  assign id_funct7 = id_instr_q[31:25];
  // next state: redirect flushes everything; otherwise issue, capture and drain the skid
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (redirect_valid) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      id_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      state_d      = rsp_done ? S_FETCH : (state_q == S_WAIT ? S_DRAIN : state_q);
    end else begin
      if (accept) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
        state_d  = S_WAIT;
      end
      if (rsp_done) state_d = S_FETCH;
      if (capture && out_free) begin
        id_valid_d = 1'b1;
        id_pc_d    = req_pc_q;
        id_instr_d = imem_rsp_data;
      end else if (capture) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = req_pc_q;
        skid_instr_d = imem_rsp_data;
      end else if (id_valid_q && id_ready) begin
        id_valid_d   = skid_valid_q;
        id_pc_d      = skid_valid_q ? skid_pc_q : id_pc_q;
        id_instr_d   = skid_valid_q ? skid_instr_q : id_instr_q;
        skid_valid_d = 1'b0;
      end
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end
endmodule
